// File: rtl/axi4lite_if.sv
// AXI4-Lite interface bundle with master and slave views.
interface axi4lite_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding command/response to AXI4-Lite master bridge.
// Optional response-wait timeout: define AXI4LITE_MASTER_TIMEOUT_EN.
module axi4lite_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  output logic                    rsp_timeout,
`endif
  axi4lite_if.master              m_axi
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // The timeout limit has to allow at least one wait cycle.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
      tcnt          <= '0;
      rsp_timeout   <= 1'b0;
`endif
    end else begin
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
      // Counter only advances while waiting for a response; any other cycle clears it.
      tcnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi.awaddr  <= cmd_addr;
              m_axi.wdata   <= cmd_wdata;
              m_axi.wstrb   <= STRB_WIDTH'(cmd_wstrb);
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi.araddr  <= cmd_addr;
              m_axi.arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        WR_REQ: begin
          if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
          if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready)) begin
            m_axi.bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            rsp_resp     <= m_axi.bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            m_axi.bready <= 1'b0;
            rsp_resp     <= 2'b10;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end else begin
            tcnt <= tcnt + TW'(1);
`endif
          end
        end

        RD_REQ: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            rsp_rdata    <= m_axi.rdata;
            rsp_resp     <= m_axi.rresp;
            rsp_valid    <= 1'b1;
            state        <= RSP;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            m_axi.rready <= 1'b0;
            rsp_resp     <= 2'b10;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end else begin
            tcnt <= tcnt + TW'(1);
`endif
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
